// File: rtl/cpu_wb_arbiter.sv
// cpu_wb_arbiter
//   Two-master (ifetch, data) to one-slave Wishbone arbiter for 128-bit line
//   transfers. One transaction is forwarded at a time. The grant is held
//   until the slave acks or the granted master drops cyc. Every grant is
//   followed by one IDLE cycle.
//
//   Optional feature macro: CPU_WB_ARB_RR_EN
//     defined   : 1-bit round-robin pointer decides simultaneous requests
//     undefined : fixed priority, the data port wins ties
//
// Ports
//   clk, rst_n                          clock, synchronous active-low reset
//   i_cyc/i_stb/i_we/i_adr/i_dat_m/i_sel ifetch master request
//   i_dat_s, i_ack                      ifetch response
//   d_cyc/d_stb/d_we/d_adr/d_dat_m/d_sel data master request
//   d_dat_s, d_ack                      data response
//   m_cyc/m_stb/m_we/m_adr/m_dat_m/m_sel downstream request
//   m_dat_s, m_ack                      downstream response
module cpu_wb_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 128,
  parameter int SEL_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cyc,
  input  logic              i_stb,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_adr,
  input  logic [DATA_W-1:0] i_dat_m,
  input  logic [SEL_W-1:0]  i_sel,
  output logic [DATA_W-1:0] i_dat_s,
  output logic              i_ack,
  input  logic              d_cyc,
  input  logic              d_stb,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_adr,
  input  logic [DATA_W-1:0] d_dat_m,
  input  logic [SEL_W-1:0]  d_sel,
  output logic [DATA_W-1:0] d_dat_s,
  output logic              d_ack,
  output logic              m_cyc,
  output logic              m_stb,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_adr,
  output logic [DATA_W-1:0] m_dat_m,
  output logic [SEL_W-1:0]  m_sel,
  input  logic [DATA_W-1:0] m_dat_s,
  input  logic              m_ack
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2} state_t;

  state_t state, state_nxt;
  logic   i_req, d_req, d_wins;

  assign i_req = i_cyc & i_stb;
  assign d_req = d_cyc & d_stb;

  // Read data is a plain pass-through; ack alone qualifies it.
  assign i_dat_s = m_dat_s;
  assign d_dat_s = m_dat_s;

`ifdef CPU_WB_ARB_RR_EN
  // rr_d = 1: data port wins the next tie. Flips only on a completed
  // transaction; aborts leave it alone.
  logic rr_d;
  always_ff @(posedge clk) begin
    if (!rst_n)
      rr_d <= 1'b1;
    else if (m_ack && state == GNT_D)
      rr_d <= 1'b0;
    else if (m_ack && state == GNT_I)
      rr_d <= 1'b1;
  end
  assign d_wins = rr_d;
`else
  assign d_wins = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    m_cyc     = 1'b0;
    m_stb     = 1'b0;
    m_we      = 1'b0;
    m_adr     = '0;
    m_dat_m   = '0;
    m_sel     = '0;
    i_ack     = 1'b0;
    d_ack     = 1'b0;
    case (state)
      IDLE: begin
        // m_ack here is stray and deliberately dropped.
        if (d_req && (!i_req || d_wins)) state_nxt = GNT_D;
        else if (i_req)                  state_nxt = GNT_I;
      end
      GNT_I: begin
        m_cyc   = i_cyc;
        m_stb   = i_stb;
        m_we    = i_we;
        m_adr   = i_adr;
        m_dat_m = i_dat_m;
        m_sel   = i_sel;
        i_ack   = m_ack;
        if (m_ack || !i_cyc) state_nxt = IDLE;
      end
      GNT_D: begin
        m_cyc   = d_cyc;
        m_stb   = d_stb;
        m_we    = d_we;
        m_adr   = d_adr;
        m_dat_m = d_dat_m;
        m_sel   = d_sel;
        d_ack   = m_ack;
        if (m_ack || !d_cyc) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
